// File: rtl/prog_clk_divider.sv
// rtl/prog_clk_divider.sv - multi-channel programmable clock divider with shadowed period/high-time reload
// Each channel runs a free counter; new settings load at the next period boundary so no period is cut short.
module prog_clk_divider #(
   parameter int SYS_CLK  = 50000000,
   parameter int DEF_FREQ = 10,
   parameter int NUM_CH   = 4,
   parameter int DIV_W    = 32,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NUM_CH-1:0] i_en,
   input  logic              i_load,
   input  logic [CH_W-1:0]   i_load_ch,
   input  logic [DIV_W-1:0]  i_div_val,
   input  logic [DIV_W-1:0]  i_high_val,
   output logic [NUM_CH-1:0] o_clk_out,
   output logic [NUM_CH-1:0] o_tick,
   output logic [NUM_CH-1:0] o_pending,
   output logic              o_err
);

   localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(SYS_CLK / DEF_FREQ);
   localparam logic [DIV_W-1:0] DEF_HIGH = DEF_DIV >> 1;

   logic w_ch_ok;
   logic w_valid;
   logic r_err;

   assign w_ch_ok = ({1'b0, i_load_ch} < (CH_W + 1)'(NUM_CH));
   assign w_valid = (i_div_val >= DIV_W'(2)) && (i_high_val != '0) &&
                    (i_high_val < i_div_val) && w_ch_ok;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_err <= 1'b0;
      else       r_err <= i_load && !w_valid;
   end

   assign o_err = r_err;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DIV_W-1:0] r_cnt;
      logic [DIV_W-1:0] r_div;
      logic [DIV_W-1:0] r_high;
      logic [DIV_W-1:0] r_sdiv;
      logic [DIV_W-1:0] r_shigh;
      logic             r_pend;
      logic             r_clk_out;
      logic             r_tick;
      logic             w_sel;
      logic             w_last;

      assign w_sel  = i_load && w_valid && (i_load_ch == CH_W'(c));
      assign w_last = (r_cnt == r_div - DIV_W'(1));

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_cnt     <= '0;
            r_div     <= DEF_DIV;
            r_high    <= DEF_HIGH;
            r_sdiv    <= DEF_DIV;
            r_shigh   <= DEF_HIGH;
            r_pend    <= 1'b0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
         end else begin
            r_clk_out <= i_en[c] && (r_cnt < r_high);
            r_tick    <= i_en[c] && w_last;
            if (!i_en[c]) begin
               // Idle channel: settings take effect at once, a leftover shadow is flushed
               r_cnt <= '0;
               if (w_sel) begin
                  r_div   <= i_div_val;
                  r_high  <= i_high_val;
                  r_sdiv  <= i_div_val;
                  r_shigh <= i_high_val;
                  r_pend  <= 1'b0;
               end else if (r_pend) begin
                  r_div  <= r_sdiv;
                  r_high <= r_shigh;
                  r_pend <= 1'b0;
               end
            end else begin
               if (w_last) begin
                  r_cnt <= '0;
                  if (r_pend) begin
                     r_div  <= r_sdiv;
                     r_high <= r_shigh;
                     r_pend <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + DIV_W'(1);
               end
               // A load on the wrap edge is written after the old shadow was consumed above
               if (w_sel) begin
                  r_sdiv  <= i_div_val;
                  r_shigh <= i_high_val;
                  r_pend  <= 1'b1;
               end
            end
         end
      end

      assign o_clk_out[c] = r_clk_out;
      assign o_tick[c]    = r_tick;
      assign o_pending[c] = r_pend;
   end

endmodule

// File: tb/tb_prog_clk_divider.sv
// tb/tb_prog_clk_divider.sv - directed bench for prog_clk_divider (SYS_CLK=100, DEF_FREQ=10, 2 channels, 8-bit)
module tb_prog_clk_divider;

   logic       clk;
   logic       rst;
   logic [1:0] en;
   logic       load;
   logic [0:0] load_ch;
   logic [7:0] div_val;
   logic [7:0] high_val;
   logic [1:0] clk_out;
   logic [1:0] tick;
   logic [1:0] pending;
   logic       err;

   int vectors;
   int miscompares;

   prog_clk_divider #(
      .SYS_CLK (100),
      .DEF_FREQ(10),
      .NUM_CH  (2),
      .DIV_W   (8)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_en      (en),
      .i_load    (load),
      .i_load_ch (load_ch),
      .i_div_val (div_val),
      .i_high_val(high_val),
      .o_clk_out (clk_out),
      .o_tick    (tick),
      .o_pending (pending),
      .o_err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Patterns list the expected value after each edge, first edge in the most significant used bit.
   task automatic expect_seq(input int n, input logic [63:0] c0, input logic [63:0] c1,
                             input logic [63:0] t0, input logic [63:0] t1, input string tag);
      for (int i = 0; i < n; i++) begin
         cyc();
         check($sformatf("%s[%0d]/clk0", tag, i), 32'(clk_out[0]), 32'(c0[n-1-i]));
         check($sformatf("%s[%0d]/clk1", tag, i), 32'(clk_out[1]), 32'(c1[n-1-i]));
         check($sformatf("%s[%0d]/tick0", tag, i), 32'(tick[0]), 32'(t0[n-1-i]));
         check($sformatf("%s[%0d]/tick1", tag, i), 32'(tick[1]), 32'(t1[n-1-i]));
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst      = 1'b1;
      en       = 2'b00;
      load     = 1'b0;
      load_ch  = 1'b0;
      div_val  = 8'd0;
      high_val = 8'd0;

      // Reset state
      cyc();
      check("rst/clk_out", 32'(clk_out), 32'd0);
      check("rst/tick", 32'(tick), 32'd0);
      check("rst/pending", 32'(pending), 32'd0);
      check("rst/err", 32'(err), 32'd0);

      // Default period 10, high 5, both channels in phase
      rst = 1'b0;
      en  = 2'b11;
      expect_seq(20, 64'b11111000001111100000, 64'b11111000001111100000,
                 64'b00000000010000000001, 64'b00000000010000000001, "def");
      expect_seq(3, 64'b111, 64'b111, 64'b000, 64'b000, "pre_ld1");

      // Mid-period load to ch1 waits for the ch1 boundary
      load = 1'b1; load_ch = 1'b1; div_val = 8'd4; high_val = 8'd1;
      cyc();
      load = 1'b0;
      check("ld1/pending", 32'(pending), 32'h2);
      check("ld1/err", 32'(err), 32'd0);
      expect_seq(5, 64'b10000, 64'b10000, 64'b00000, 64'b00000, "ld1_wait");
      check("ld1_wait/pending", 32'(pending), 32'h2);
      expect_seq(1, 64'b0, 64'b0, 64'b1, 64'b1, "ld1_wrap");
      check("ld1_wrap/pending", 32'(pending), 32'h0);
      expect_seq(12, 64'b111110000011, 64'b100010001000,
                 64'b000000000100, 64'b000100010001, "ld1_run");

      // Rejected loads: period 1, and high equal to period
      load = 1'b1; load_ch = 1'b0; div_val = 8'd1; high_val = 8'd1;
      cyc();
      check("bad1/err", 32'(err), 32'd1);
      check("bad1/pending", 32'(pending), 32'h0);
      div_val = 8'd6; high_val = 8'd6;
      cyc();
      load = 1'b0;
      check("bad2/err", 32'(err), 32'd1);
      check("bad2/pending", 32'(pending), 32'h0);
      cyc();
      check("bad_clr/err", 32'(err), 32'd0);
      expect_seq(10, 64'b0000011111, 64'b0100010001,
                 64'b0000100000, 64'b1000100010, "bad_after");

      // Two loads before the boundary: last one wins
      load = 1'b1; load_ch = 1'b0; div_val = 8'd8; high_val = 8'd4;
      cyc();
      div_val = 8'd3; high_val = 8'd2;
      cyc();
      load = 1'b0;
      check("dbl/pending", 32'(pending), 32'h1);
      check("dbl/err", 32'(err), 32'd0);
      expect_seq(3, 64'b000, 64'b010, 64'b001, 64'b100, "dbl_wait");
      check("dbl_wrap/pending", 32'(pending), 32'h0);
      expect_seq(12, 64'b110110110110, 64'b001000100010,
                 64'b001001001001, 64'b010001000100, "dbl_run");

      // Disable ch0 for 7 cycles mid-period, then restart from count 0
      expect_seq(1, 64'b1, 64'b0, 64'b0, 64'b0, "pre_dis");
      en = 2'b10;
      expect_seq(7, 64'b0000000, 64'b0100010, 64'b0000000, 64'b1000100, "dis");
      en = 2'b11;
      expect_seq(6, 64'b110110, 64'b001000, 64'b001001, 64'b010001, "reen");

      // Reset with a shadow pending on ch1 discards it
      load = 1'b1; load_ch = 1'b1; div_val = 8'd6; high_val = 8'd3;
      cyc();
      load = 1'b0;
      check("prst/pending", 32'(pending), 32'h2);
      rst = 1'b1;
      cyc();
      check("rst2/clk_out", 32'(clk_out), 32'd0);
      check("rst2/tick", 32'(tick), 32'd0);
      check("rst2/pending", 32'(pending), 32'd0);
      check("rst2/err", 32'(err), 32'd0);
      rst = 1'b0;
      expect_seq(20, 64'b11111000001111100000, 64'b11111000001111100000,
                 64'b00000000010000000001, 64'b00000000010000000001, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
